// File: rtl/wb_mux_pipe.sv
// Write-back stage: selects one of NSRC sources, aligns/extends load data, and holds the result
// in a single valid/ready pipeline register that also counts retired register writes.
module wb_mux_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NSRC    = 4,
  parameter int unsigned SELW    = 2,
  parameter int unsigned MEM_SRC = 1,
  parameter int unsigned REGW    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [SELW-1:0]       in_sel_i,
  input  logic [NSRC*WIDTH-1:0] src_data_i,
  input  logic [1:0]            ld_size_i,
  input  logic                  ld_signed_i,
  input  logic [1:0]            byte_off_i,
  input  logic [REGW-1:0]       rd_addr_i,
  input  logic                  reg_write_i,
  input  logic                  flush_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [WIDTH-1:0]      wb_data_o,
  output logic [REGW-1:0]       wb_addr_o,
  output logic                  wb_en_o,
  output logic [31:0]           wb_count_o
);

  logic [WIDTH-1:0] sel_val, res;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [REGW-1:0]  addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      count_q, count_d;
  logic             accept, retire;

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_val = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (in_sel_i == SELW'(k)) sel_val = src_data_i[k*WIDTH +: WIDTH];
    end
  end

  assign ld_byte = sel_val[{byte_off_i, 3'b000} +: 8];
  assign ld_half = sel_val[{byte_off_i[1], 4'b0000} +: 16];

  always_comb begin
    res = sel_val;
    if (in_sel_i == SELW'(MEM_SRC)) begin
      case (ld_size_i)
        2'b00:   res = {{(WIDTH-8){ld_signed_i & ld_byte[7]}}, ld_byte};
        2'b01:   res = {{(WIDTH-16){ld_signed_i & ld_half[15]}}, ld_half};
        default: res = sel_val;
      endcase
    end
  end

  assign in_ready_o = !valid_q || wb_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign retire     = valid_q && wb_ready_i;

  assign wb_valid_o = valid_q;
  assign wb_data_o  = data_q;
  assign wb_addr_o  = addr_q;
  assign wb_en_o    = valid_q && we_q && (addr_q != '0);
  assign wb_count_o = count_q;

  // Flush kills both the held beat and any beat offered alongside it, without counting.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = we_q;
    count_d = count_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else begin
      if (retire && wb_en_o) count_d = count_q + 32'd1;
      if (accept) begin
        valid_d = 1'b1;
        data_d  = res;
        addr_d  = rd_addr_i;
        we_d    = reg_write_i;
      end else if (retire) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_wb_mux_pipe.sv
// Scoreboard bench for wb_mux_pipe (NSRC=3 so select 3 is out of range).
module tb_wb_mux_pipe;

  localparam int unsigned W = 32;
  localparam int unsigned N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [1:0]    in_sel;
  logic [N*W-1:0] src_data;
  logic [1:0]    ld_size;
  logic          ld_signed;
  logic [1:0]    byte_off;
  logic [4:0]    rd_addr;
  logic          reg_write, flush;
  logic          wb_valid, wb_ready;
  logic [W-1:0]  wb_data;
  logic [4:0]    wb_addr;
  logic          wb_en;
  logic [31:0]   wb_count;

  wb_mux_pipe #(.WIDTH(W), .NSRC(N), .SELW(2), .MEM_SRC(1), .REGW(5)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_sel_i(in_sel), .src_data_i(src_data), .ld_size_i(ld_size), .ld_signed_i(ld_signed),
    .byte_off_i(byte_off), .rd_addr_i(rd_addr), .reg_write_i(reg_write), .flush_i(flush),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_addr_o(wb_addr),
    .wb_en_o(wb_en), .wb_count_o(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        en;
  } beat_t;

  beat_t       sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_count = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] val, input logic [1:0] sz,
                       input logic sg, input logic [1:0] off, input logic [4:0] rd,
                       input logic we);
    src_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    if (sel < 2'd3) src_data[32*int'(sel) +: 32] = val;
    in_sel    = sel;
    ld_size   = sz;
    ld_signed = sg;
    byte_off  = off;
    rd_addr   = rd;
    reg_write = we;
    in_valid  = 1'b1;
  endtask

  // Called at a posedge; returns at the posedge where the beat is accepted.
  task automatic send(input logic [1:0] sel, input logic [31:0] val, input logic [1:0] sz,
                      input logic sg, input logic [1:0] off, input logic [4:0] rd,
                      input logic we, input logic [31:0] exp);
    logic acc;
    beat_t b;
    #1;
    drive(sel, val, sz, sg, off, rd, we);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      if (acc) begin
        b.data = exp;
        b.addr = rd;
        b.en   = we && (rd != 5'd0);
        sb.push_back(b);
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    #1 in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: compares every retiring beat against the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_count = 32'd0;
      end else if (wb_valid) begin
        if (flush) begin
          if (sb.size() > 0) void'(sb.pop_front());
        end else if (wb_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", {31'd0, wb_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("wb_data", wb_data, e.data);
            chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
            chk("wb_en", {31'd0, wb_en}, {31'd0, e.en});
            chk("wb_count", wb_count, exp_count);
            if (e.en) exp_count = exp_count + 32'd1;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    drive(2'd0, 32'd0, 2'd2, 1'b0, 2'd0, 5'd0, 1'b0);
    in_valid = 1'b0;
    #12;
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_en", {31'd0, wb_en}, 32'd0);
    chk("rst_count", wb_count, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic source select and load alignment, back to back.
    send(2'd0, 32'h1234_5678, 2'd2, 1'b0, 2'd0, 5'd3, 1'b1, 32'h1234_5678);
    send(2'd1, 32'h80FF_7F01, 2'd0, 1'b1, 2'd2, 5'd4, 1'b1, 32'hFFFF_FFFF);
    send(2'd1, 32'h80FF_7F01, 2'd0, 1'b0, 2'd1, 5'd5, 1'b1, 32'h0000_007F);
    send(2'd1, 32'h80FF_7F01, 2'd1, 1'b1, 2'd2, 5'd6, 1'b1, 32'hFFFF_80FF);
    send(2'd1, 32'h80FF_7F01, 2'd1, 1'b1, 2'd1, 5'd7, 1'b1, 32'h0000_7F01);
    send(2'd1, 32'h80FF_7F01, 2'd0, 1'b0, 2'd3, 5'd8, 1'b1, 32'h0000_0080);
    send(2'd1, 32'h80FF_7F01, 2'd3, 1'b1, 2'd1, 5'd9, 1'b1, 32'h80FF_7F01);
    send(2'd2, 32'hCAFE_BABE, 2'd0, 1'b1, 2'd0, 5'd10, 1'b1, 32'hCAFE_BABE);
    send(2'd3, 32'hDEAD_BEEF, 2'd2, 1'b0, 2'd0, 5'd11, 1'b1, 32'h0000_0000);
    send(2'd0, 32'h5555_AAAA, 2'd2, 1'b0, 2'd0, 5'd0, 1'b1, 32'h5555_AAAA);
    send(2'd0, 32'h0F0F_0F0F, 2'd2, 1'b0, 2'd0, 5'd12, 1'b0, 32'h0F0F_0F0F);
    idle(2);
    chk("count_after_basic", wb_count, 32'd9);

    // Stall: held output stays put while a second beat waits.
    wb_ready = 1'b0;
    send(2'd0, 32'hA5A5_A5A5, 2'd2, 1'b0, 2'd0, 5'd13, 1'b1, 32'hA5A5_A5A5);
    #1 drive(2'd2, 32'h0BAD_F00D, 2'd2, 1'b0, 2'd0, 5'd14, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, wb_valid}, 32'd1);
      chk("stall_data", wb_data, 32'hA5A5_A5A5);
      chk("stall_addr", {27'd0, wb_addr}, 32'd13);
      chk("stall_count", wb_count, 32'd9);
      @(posedge clk);
    end
    #1 wb_ready = 1'b1;
    send(2'd2, 32'h0BAD_F00D, 2'd2, 1'b0, 2'd0, 5'd14, 1'b1, 32'h0BAD_F00D);
    send(2'd1, 32'h1234_8765, 2'd1, 1'b0, 2'd0, 5'd15, 1'b1, 32'h0000_8765);
    idle(2);
    chk("count_after_stall", wb_count, 32'd12);

    // Flush while a beat is held and another is offered.
    wb_ready = 1'b0;
    send(2'd0, 32'h7777_7777, 2'd2, 1'b0, 2'd0, 5'd16, 1'b1, 32'h7777_7777);
    #1;
    wb_ready = 1'b1;
    flush    = 1'b1;
    drive(2'd0, 32'h9999_9999, 2'd2, 1'b0, 2'd0, 5'd17, 1'b1);
    @(posedge clk);
    #1;
    chk("flush_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_count", wb_count, 32'd12);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    chk("flush_discard", {31'd0, wb_valid}, 32'd0);

    // Asynchronous reset mid-stall.
    wb_ready = 1'b0;
    send(2'd0, 32'h4444_4444, 2'd2, 1'b0, 2'd0, 5'd18, 1'b1, 32'h4444_4444);
    #1 in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, wb_valid}, 32'd0);
    chk("arst_data", wb_data, 32'd0);
    chk("arst_addr", {27'd0, wb_addr}, 32'd0);
    chk("arst_en", {31'd0, wb_en}, 32'd0);
    chk("arst_count", wb_count, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    wb_ready = 1'b1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    send(2'd0, 32'h2468_ACE0, 2'd2, 1'b0, 2'd0, 5'd19, 1'b1, 32'h2468_ACE0);
    idle(2);
    chk("post_rst_count", wb_count, 32'd1);

    // Counter wrap from a forced preload.
    #1 force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    exp_count = 32'hFFFF_FFFF;
    @(posedge clk);
    send(2'd0, 32'h1357_9BDF, 2'd2, 1'b0, 2'd0, 5'd20, 1'b1, 32'h1357_9BDF);
    idle(2);
    chk("count_wrap", wb_count, 32'd0);

    idle(2);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
